vga_scan_driver: RTL

//  VGA scan engine upstream/downstream of the register-heap renderer: generates pixel coords x,y

---
 rtl/vga_timing_pkg.sv | 31 +++
 rtl/vga_axis_counter.sv | 33 +++
 rtl/vga_scan_driver.sv | 85 ++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared timing defaults, counter width and colour helpers for the VGA scan engine.
package vga_timing_pkg;
    localparam int CNT_W = 11;

    localparam int H_VISIBLE_DFLT = 800;
    localparam int H_FRONT_DFLT   = 56;
    localparam int H_SYNC_DFLT    = 120;
    localparam int H_BACK_DFLT    = 64;
    localparam int H_TOTAL_DFLT   = H_VISIBLE_DFLT + H_FRONT_DFLT + H_SYNC_DFLT + H_BACK_DFLT;
    localparam int H_SYNC_START_DFLT = H_VISIBLE_DFLT + H_FRONT_DFLT;

    localparam int V_VISIBLE_DFLT = 600;
    localparam int V_FRONT_DFLT   = 37;
    localparam int V_SYNC_DFLT    = 6;
    localparam int V_BACK_DFLT    = 23;
    localparam int V_TOTAL_DFLT   = V_VISIBLE_DFLT + V_FRONT_DFLT + V_SYNC_DFLT + V_BACK_DFLT;
    localparam int V_SYNC_START_DFLT = V_VISIBLE_DFLT + V_FRONT_DFLT;

    // {r[2:0],g[2:0],b[2:0]}
    typedef logic [8:0] color_t;

    localparam color_t FG_COLOR_DFLT = 9'h1FF;
    localparam color_t BG_COLOR_DFLT = 9'h000;

    // Blanking always outputs black regardless of the renderer's hit.
    function automatic color_t pixel_color(input logic active, input logic hit,
                                           input color_t fg, input color_t bg);
        if (!active) return '0;
        return hit ? fg : bg;
    endfunction
endpackage

// File: rtl/vga_axis_counter.sv
// One scan axis: wrapping position counter plus visible/sync decode of the current count.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int TOTAL      = H_TOTAL_DFLT,
    parameter int VISIBLE    = H_VISIBLE_DFLT,
    parameter int SYNC_START = H_SYNC_START_DFLT,
    parameter int SYNC_LEN   = H_SYNC_DFLT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             wrap,
    output logic             active,
    output logic             sync_pre
);
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] VIS_END  = CNT_W'(VISIBLE);
    localparam logic [CNT_W-1:0] SYNC_BEG = CNT_W'(SYNC_START);
    localparam logic [CNT_W-1:0] SYNC_END = CNT_W'(SYNC_START + SYNC_LEN);

    // Position counter; advances only when enabled, wraps at the last position.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      count <= '0;
        else if (en)   count <= wrap ? '0 : count + 1'b1;
    end

    // Terminal count is independent of en so the vertical axis can chain off it.
    assign wrap     = (count == LAST);
    assign active   = (count < VIS_END);
    assign sync_pre = (count >= SYNC_BEG) && (count < SYNC_END);
endmodule

// File: rtl/vga_scan_driver.sv
// VGA scan engine: x/y generation, per-frame register snapshot, one-stage colour/sync output.
module vga_scan_driver
    import vga_timing_pkg::*;
#(
    parameter int     H_VISIBLE = H_VISIBLE_DFLT,
    parameter int     H_FRONT   = H_FRONT_DFLT,
    parameter int     H_SYNC    = H_SYNC_DFLT,
    parameter int     H_BACK    = H_BACK_DFLT,
    parameter int     V_VISIBLE = V_VISIBLE_DFLT,
    parameter int     V_FRONT   = V_FRONT_DFLT,
    parameter int     V_SYNC    = V_SYNC_DFLT,
    parameter int     V_BACK    = V_BACK_DFLT,
    parameter bit     SYNC_POL  = 1'b1,
    parameter int     REG_BITS  = 176,
    parameter color_t FG_COLOR  = FG_COLOR_DFLT,
    parameter color_t BG_COLOR  = BG_COLOR_DFLT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [REG_BITS-1:0] cpu_registers,
    input  logic                hit,
    output logic [CNT_W-1:0]    x,
    output logic [CNT_W-1:0]    y,
    output logic [REG_BITS-1:0] frame_registers,
    output logic                frame_start,
    output logic [2:0]          vga_r,
    output logic [2:0]          vga_g,
    output logic [2:0]          vga_b,
    output logic                hsync,
    output logic                vsync
);
    localparam logic [CNT_W-1:0] SNAP_Y = CNT_W'(V_VISIBLE);

    logic   h_wrap, h_active, hs_pre;
    logic   v_wrap, v_active, vs_pre;
    logic   active;
    color_t rgb_q;

    vga_axis_counter #(
        .TOTAL(H_VISIBLE + H_FRONT + H_SYNC + H_BACK), .VISIBLE(H_VISIBLE),
        .SYNC_START(H_VISIBLE + H_FRONT), .SYNC_LEN(H_SYNC)
    ) u_h (
        .clk(clk), .rst(rst), .en(1'b1),
        .count(x), .wrap(h_wrap), .active(h_active), .sync_pre(hs_pre)
    );

    vga_axis_counter #(
        .TOTAL(V_VISIBLE + V_FRONT + V_SYNC + V_BACK), .VISIBLE(V_VISIBLE),
        .SYNC_START(V_VISIBLE + V_FRONT), .SYNC_LEN(V_SYNC)
    ) u_v (
        .clk(clk), .rst(rst), .en(h_wrap),
        .count(y), .wrap(v_wrap), .active(v_active), .sync_pre(vs_pre)
    );

    assign active = h_active & v_active;

    // Capture the CPU bus once, at the start of the first blank line, so the renderer sees a stable frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                          frame_registers <= '0;
        else if (x == '0 && y == SNAP_Y)   frame_registers <= cpu_registers;
    end

    // Colour and sync share one register stage so they stay aligned, one clock behind x/y.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rgb_q <= '0;
            hsync <= ~SYNC_POL;
            vsync <= ~SYNC_POL;
        end else begin
            rgb_q <= pixel_color(active, hit, FG_COLOR, BG_COLOR);
            hsync <= hs_pre ? SYNC_POL : ~SYNC_POL;
            vsync <= vs_pre ? SYNC_POL : ~SYNC_POL;
        end
    end

    // Registered from the wrap condition so it is high exactly while the counters read (0,0).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) frame_start <= 1'b0;
        else      frame_start <= h_wrap & v_wrap;
    end

    assign vga_r = rgb_q[8:6];
    assign vga_g = rgb_q[5:3];
    assign vga_b = rgb_q[2:0];
endmodule
